// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Memory-access stage. Resolves branches and jumps, runs a
//               req/ack data-memory access with timeout and misalignment
//               check, stalls upstream while busy and registers MEM/WB state.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] adderout_in,
    input  logic        zero_in,
    input  logic [63:0] alu_result_in,
    input  logic [63:0] writedata_in,
    input  logic [4:0]  rd_in,
    input  logic        branch_in,
    input  logic        memread_in,
    input  logic        memtoreg_in,
    input  logic        memwrite_in,
    input  logic        regwrite_in,
    input  logic        addermuxselect_in,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic        flush_out,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        exc_misaligned,
    output logic        exc_bus_timeout
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        exc_mis_q, exc_mis_d;
    logic        exc_to_q, exc_to_d;

    logic w_access;
    logic w_misaligned;
    logic w_req;
    logic w_stall;
    logic w_timeout;

    assign w_access     = memread_in | memwrite_in;
    assign w_misaligned = w_access & (alu_result_in[2:0] != 3'b000);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        w_req     = 1'b0;
        w_stall   = 1'b0;
        w_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_access && !w_misaligned) begin
                    w_req = 1'b1;
                    if (!dmem_ack) begin
                        w_stall = 1'b1;
                        state_d = S_WAIT;
                        count_d = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                // Abandon the access once the wait budget is spent; the
                // instruction leaves the stage without a register write.
                if (count_q == c_TIMEOUT) begin
                    w_timeout = 1'b1;
                    state_d   = S_IDLE;
                    count_d   = 8'd0;
                end else begin
                    w_req = 1'b1;
                    if (dmem_ack) begin
                        state_d = S_IDLE;
                        count_d = 8'd0;
                    end else begin
                        w_stall = 1'b1;
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 8'd0;
            end
        endcase
        if (reset) begin
            state_d   = S_IDLE;
            count_d   = 8'd0;
            w_req     = 1'b0;
            w_stall   = 1'b0;
            w_timeout = 1'b0;
        end
    end

    // A stalled cycle inserts a bubble: write enable drops, data/rd hold.
    always_comb begin
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = 1'b0;
        exc_mis_d     = 1'b0;
        exc_to_d      = 1'b0;
        if (reset) begin
            wb_data_d = 64'd0;
            wb_rd_d   = 5'd0;
        end else if (!w_stall) begin
            wb_rd_d       = rd_in;
            wb_data_d     = memtoreg_in ? dmem_rdata : alu_result_in;
            wb_regwrite_d = regwrite_in & ~w_misaligned & ~w_timeout;
            exc_mis_d     = w_misaligned & (state_q == S_IDLE);
            exc_to_d      = w_timeout;
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        count_q       <= count_d;
        wb_data_q     <= wb_data_d;
        wb_rd_q       <= wb_rd_d;
        wb_regwrite_q <= wb_regwrite_d;
        exc_mis_q     <= exc_mis_d;
        exc_to_q      <= exc_to_d;
    end

    assign pc_src          = ~reset & ((branch_in & zero_in) | addermuxselect_in);
    assign flush_out       = pc_src;
    assign branch_target   = addermuxselect_in ? {alu_result_in[63:1], 1'b0} : adderout_in;
    assign stall           = w_stall;
    assign dmem_req        = w_req;
    assign dmem_we         = memwrite_in & ~memread_in;
    assign dmem_addr       = alu_result_in;
    assign dmem_wdata      = writedata_in;
    assign wb_data         = wb_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_regwrite     = wb_regwrite_q;
    assign exc_misaligned  = exc_mis_q;
    assign exc_bus_timeout = exc_to_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage (vector table plus
//               multi-cycle sequences, MEM/WB results via a scoreboard queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic [63:0] adderout_in, alu_result_in, writedata_in, dmem_rdata;
    logic        zero_in, branch_in, memread_in, memtoreg_in, memwrite_in;
    logic        regwrite_in, addermuxselect_in, dmem_ack;
    logic [4:0]  rd_in;
    logic        pc_src, flush_out, stall, dmem_req, dmem_we;
    logic [63:0] branch_target, dmem_addr, dmem_wdata, wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite, exc_misaligned, exc_bus_timeout;

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .adderout_in(adderout_in), .zero_in(zero_in), .alu_result_in(alu_result_in),
        .writedata_in(writedata_in), .rd_in(rd_in), .branch_in(branch_in),
        .memread_in(memread_in), .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
        .regwrite_in(regwrite_in), .addermuxselect_in(addermuxselect_in),
        .pc_src(pc_src), .branch_target(branch_target), .flush_out(flush_out),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .exc_misaligned(exc_misaligned), .exc_bus_timeout(exc_bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl  = {zero, branch, memread, memtoreg, memwrite, regwrite, jump, ack}
    // eflg = {pc_src, req, we, wb_regwrite, exc_misaligned}
    typedef struct {
        logic [63:0] adderout;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic [7:0]  ctl;
        logic [63:0] target;
        logic [4:0]  eflg;
        logic [63:0] wbdata;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        to;
    } wb_exp_t;

    wb_exp_t     sb[$];
    vec_t        vecs[10];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [63:0] last_data = 64'd0;
    logic [4:0]  last_rd   = 5'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL c%0d %s: got %0h expected %0h", cyc, nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 64'(act), 64'(exp));
    endtask

    task automatic push(input logic [63:0] d, input logic [4:0] r, input logic rw,
                        input logic mis, input logic to);
        wb_exp_t e;
        e.data = d; e.rd = r; e.rw = rw; e.mis = mis; e.to = to;
        sb.push_back(e);
        last_data = d;
        last_rd   = r;
    endtask

    task automatic push_bubble();
        push(last_data, last_rd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic edge_check();
        wb_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL c%0d scoreboard: got empty queue expected an entry", cyc);
        end else begin
            e = sb.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_rd", 64'(wb_rd), 64'(e.rd));
            chk1("wb_regwrite", wb_regwrite, e.rw);
            chk1("exc_misaligned", exc_misaligned, e.mis);
            chk1("exc_bus_timeout", exc_bus_timeout, e.to);
        end
    endtask

    task automatic comb_check(input logic e_stall, input logic e_req);
        @(negedge clk);
        chk1("stall", stall, e_stall);
        chk1("dmem_req", dmem_req, e_req);
    endtask

    task automatic set_in(input vec_t v);
        adderout_in = v.adderout; alu_result_in = v.alu; writedata_in = v.wdata;
        dmem_rdata  = v.rdata;    rd_in = v.rd;
        {zero_in, branch_in, memread_in, memtoreg_in, memwrite_in,
         regwrite_in, addermuxselect_in, dmem_ack} = v.ctl;
    endtask

    task automatic set_load(input logic [63:0] addr, input logic [4:0] rd,
                            input logic [63:0] rdata, input logic ack);
        vec_t v;
        v.adderout = 64'd0; v.alu = addr; v.wdata = 64'd0; v.rdata = rdata; v.rd = rd;
        v.ctl = {6'b001101, 1'b0, ack};
        v.target = 64'd0; v.eflg = 5'd0; v.wbdata = 64'd0;
        set_in(v);
    endtask

    initial begin
        vecs[0] = '{64'h0,   64'h1234, 64'h0,  64'h0,        5'd5, 8'b00000100, 64'h0,   5'b00010, 64'h1234};
        vecs[1] = '{64'h0,   64'h100,  64'h0,  64'hDEADBEEF, 5'd7, 8'b00110101, 64'h0,   5'b01010, 64'hDEADBEEF};
        vecs[2] = '{64'h0,   64'h103,  64'h0,  64'h55,       5'd9, 8'b00110100, 64'h0,   5'b00001, 64'h55};
        vecs[3] = '{64'h400, 64'h0,    64'h0,  64'h0,        5'd0, 8'b11000000, 64'h400, 5'b10000, 64'h0};
        vecs[4] = '{64'h400, 64'h0,    64'h0,  64'h0,        5'd0, 8'b01000000, 64'h400, 5'b00000, 64'h0};
        vecs[5] = '{64'h999, 64'h501,  64'h0,  64'h0,        5'd1, 8'b00000110, 64'h500, 5'b10010, 64'h501};
        vecs[6] = '{64'h0,   64'hF8,   64'hBB, 64'h77,       5'd2, 8'b00111101, 64'h0,   5'b01010, 64'h77};
        vecs[7] = '{64'h0,   64'h42,   64'h0,  64'h999,      5'd3, 8'b00000101, 64'h0,   5'b00010, 64'h42};
        vecs[8] = '{64'h0,   64'h10,   64'hBB, 64'h0,        5'd4, 8'b00001001, 64'h0,   5'b01100, 64'h10};
        vecs[9] = '{64'h0,   64'hC,    64'h1,  64'h0,        5'd8, 8'b00001001, 64'h0,   5'b00101, 64'hC};

        // Reset with a jump and aligned load presented: all forced quiet.
        reset = 1'b1;
        set_load(64'h200, 5'd3, 64'h0, 1'b0);
        addermuxselect_in = 1'b1;
        @(posedge clk);
        #1;
        comb_check(1'b0, 1'b0);
        chk1("pc_src_rst", pc_src, 1'b0);
        chk1("flush_rst", flush_out, 1'b0);
        push(64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        edge_check();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i]);
            comb_check(1'b0, vecs[i].eflg[3]);
            chk1("pc_src", pc_src, vecs[i].eflg[4]);
            chk1("flush_out", flush_out, vecs[i].eflg[4]);
            chk("branch_target", branch_target, vecs[i].target);
            chk1("dmem_we", dmem_we, vecs[i].eflg[2]);
            if (vecs[i].eflg[3]) begin
                chk("dmem_addr", dmem_addr, vecs[i].alu);
                chk("dmem_wdata", dmem_wdata, vecs[i].wdata);
            end
            push(vecs[i].wbdata, vecs[i].rd, vecs[i].eflg[1], vecs[i].eflg[0], 1'b0);
            edge_check();
        end

        // Reset mid-stream clears MEM/WB state.
        reset = 1'b1;
        set_load(64'h200, 5'd3, 64'h0, 1'b0);
        addermuxselect_in = 1'b1;
        comb_check(1'b0, 1'b0);
        chk1("pc_src_rst2", pc_src, 1'b0);
        push(64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        edge_check();
        reset = 1'b0;
        addermuxselect_in = 1'b0;

        // Store acked on the third request cycle.
        set_load(64'h208, 5'd4, 64'h0, 1'b0);
        {memread_in, memtoreg_in, memwrite_in, regwrite_in} = 4'b0010;
        writedata_in = 64'hAA;
        for (int k = 0; k < 3; k++) begin
            dmem_ack = (k == 2);
            comb_check(k != 2, 1'b1);
            chk1("st_we", dmem_we, 1'b1);
            chk("st_addr", dmem_addr, 64'h208);
            chk("st_wdata", dmem_wdata, 64'hAA);
            if (k == 2) push(64'h208, 5'd4, 1'b0, 1'b0, 1'b0);
            else        push_bubble();
            edge_check();
        end

        // Load with no ack: four stall cycles, then abandoned.
        set_load(64'h300, 5'd6, 64'h11, 1'b0);
        for (int k = 0; k < 4; k++) begin
            comb_check(1'b1, 1'b1);
            push_bubble();
            edge_check();
        end
        comb_check(1'b0, 1'b0);
        push(64'h11, 5'd6, 1'b0, 1'b0, 1'b1);
        edge_check();

        // Next load proceeds normally; timeout pulse is gone.
        set_load(64'h308, 5'd6, 64'hCAFE, 1'b1);
        comb_check(1'b0, 1'b1);
        push(64'hCAFE, 5'd6, 1'b1, 1'b0, 1'b0);
        edge_check();

        // Reset while waiting returns the FSM to IDLE.
        set_load(64'h400, 5'd2, 64'h0, 1'b0);
        comb_check(1'b1, 1'b1);
        push_bubble();
        edge_check();
        reset = 1'b1;
        comb_check(1'b0, 1'b0);
        push(64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        edge_check();
        reset = 1'b0;
        set_in('{64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 8'b00000000, 64'h0, 5'b00000, 64'h0});
        comb_check(1'b0, 1'b0);
        push(64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        edge_check();

        // A fresh load after the reset waits the full budget again.
        set_load(64'h408, 5'd2, 64'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            comb_check(1'b1, 1'b1);
            push_bubble();
            edge_check();
        end
        comb_check(1'b0, 1'b0);
        push(64'h0, 5'd2, 1'b0, 1'b0, 1'b1);
        edge_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
